load_store_unit: RTL and testbench
==================================

# load_store_unit

- Initiator-side load/store unit that sits between the core's execute/memory stage and the word-wide data memory.
- Accepts one load or store request at a time and always drives the memory with full-word accesses.
  - Loads: extracts and sign/zero-extends the selected byte/half internally.
  - Sub-word stores: performs a read-modify-write, because the memory overwrites a whole word on every write.
- Returns a response under a valid/ready handshake and stalls the core while busy.

## Interface
Parameters:
- DATA_WIDTH, 32, data and address width
- MEM_ADDR_SIZE, 13, word-address bits forwarded to memory (address bits [MEM_ADDR_SIZE+1:2] are significant)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores)
- req_addr  in  DATA_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data (low bits used for B/H)
- resp_valid  out  1  response available
- resp_ready  in  1  core consumes response
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores
- resp_error  out  1  misaligned access (see Configuration)
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable (memory samples on falling edge)
- mem_maskmode  out  2  always 2'b10 (word)
- mem_sext  out  1  always 0
- mem_address  out  DATA_WIDTH  word-aligned address (req_addr with [1:0] = 0)
- mem_write_data  out  DATA_WIDTH  full merged word
- mem_read_data  in  DATA_WIDTH  combinational read data from memory

## Operation
States:
- IDLE: req_ready = 1.
  - On req_valid, latch write/funct3/addr/wdata.
  - Next state: READ for loads and sub-word stores; WRITE for word stores; RESP for a trapped misaligned access.
- READ:
  - Assert mem_read = 1 and capture mem_read_data into the word register.
  - Next state: RESP for loads, WRITE for stores.
- WRITE:
  - Assert mem_write = 1 for exactly one cycle, with mem_write_data = merged word.
  - Merge inserts byte/half at byte offset addr[1:0] into the captured word; a word store passes req_wdata straight through.
  - Next state: RESP.
- RESP:
  - resp_valid = 1; hold resp_rdata and resp_error stable until resp_ready.
  - On resp_ready, return to IDLE.

Load extraction:
- Shift the word right by 8·addr[1:0].
- B/H: sign-extend bit 7/15.
- BU/HU: zero-extend.
- W: pass the word through.

Undefined funct3 (011, 110, 111): treated as W.

mem_read and mem_write are never high in the same cycle and are 0 outside READ/WRITE.

Reset:
- Any cycle with reset high forces IDLE and clears all registers.
- This aborts an in-flight access; a write already in WRITE that cycle is suppressed (mem_write = 0).
- Reset values: req_ready = 1; resp_valid, resp_rdata, resp_error, mem_read, mem_write, mem_address, mem_write_data = 0; mem_maskmode = 2'b10; mem_sext = 0.

## Timing
Latency, counted from the accept edge to the first resp_valid cycle:
- Load: 2 cycles.
- Word store: 2 cycles.
- Sub-word store: 3 cycles.
- Trapped misaligned access: 1 cycle.

Throughput:
- Next accept is possible in the cycle after the resp_valid/resp_ready handshake.
- No request overlap.

Handshake and hazards:
- Back-pressure: resp_valid stays high indefinitely while resp_ready = 0.
- req_valid while busy is ignored (req_ready = 0); the core must hold the request.
- The write lands at the falling edge inside WRITE, so a load accepted right after the store completes observes the new data.

## Configuration
LSU_MISALIGN_TRAP_EN
- Misaligned cases: H with addr[0] = 1, or W with addr[1:0] ≠ 0.
- Defined: a misaligned access does no memory access, goes IDLE→RESP, and responds with resp_error = 1 and resp_rdata = 0.
- Undefined: the offending low address bits are forced to 0 (H clears addr[0]; W clears addr[1:0]), the access proceeds normally, and resp_error is tied to 0.

## Structure
- Package lsu_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum (IDLE, READ, WRITE, RESP), MASK_WORD = 2'b10.
- Sub-module lsu_byte_lane: purely combinational.
  - Store merge: old word, wdata, offset, size → merged word.
  - Load extract: word, offset, funct3 → extended data.
- load_store_unit owns the FSM, registers and handshakes.

## Test plan
- Memory word 0x40 = 0x8899AABB; LB at 0x43 → resp_rdata 0xFFFFFF88 at cycle 2; LBU at 0x43 → 0x00000088.
- SB 0x5A at 0x41 over 0x8899AABB → exactly one mem_read then one mem_write of 0x88995ABB; resp_valid at cycle 3.
- SW 0x12345678 at 0x80 → no mem_read, one mem_write of 0x12345678; a following LW at 0x80 → 0x12345678.
- resp_ready held 0 for 5 cycles → resp_valid and resp_rdata stable; req_ready = 0 throughout; a new req_valid is not accepted.
- LH at 0x43 → with LSU_MISALIGN_TRAP_EN: resp_error = 1, no mem_read/mem_write; without: reads 0x40, returns the half at offset 2 (0xFFFF8899), resp_error = 0.
- Reset asserted in the WRITE cycle of a SB → mem_write = 0, memory unchanged, next cycle req_ready = 1 and resp_valid = 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// access-size decode and the fixed word mask mode driven to memory.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] MASK_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } lsu_size_t;

  // Undefined encodings (011, 110, 111) decode as word accesses.
  function automatic lsu_size_t f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane logic: merges store data into a fetched word and
// extracts/extends load data from a word. No state, zero latency.
module lsu_byte_lane
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [1:0]            offset,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] merged,
  output logic [DATA_WIDTH-1:0] extracted
);

  localparam int SHW = $clog2(DATA_WIDTH);

  logic [SHW-1:0]        sh;
  logic [DATA_WIDTH-1:0] lane_mask;
  logic [DATA_WIDTH-1:0] lane_data;
  logic [DATA_WIDTH-1:0] shifted;

  assign sh      = SHW'({offset, 3'b000});
  assign shifted = word >> sh;

  always_comb begin
    lane_mask = '0;
    lane_data = '0;
    case (f3_size(funct3))
      SZ_B: begin
        lane_mask = DATA_WIDTH'(8'hFF) << sh;
        lane_data = DATA_WIDTH'(wdata[7:0]) << sh;
      end
      SZ_H: begin
        lane_mask = DATA_WIDTH'(16'hFFFF) << sh;
        lane_data = DATA_WIDTH'(wdata[15:0]) << sh;
      end
      default: begin
        lane_mask = '1;
        lane_data = wdata;
      end
    endcase
    merged = (word & ~lane_mask) | (lane_data & lane_mask);
  end

  always_comb begin
    case (funct3)
      F3_B:    extracted = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      F3_BU:   extracted = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      F3_H:    extracted = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      F3_HU:   extracted = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default: extracted = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, full-word memory accesses, RMW for sub-word stores;
// 2-cycle load/word store, 3-cycle sub-word store, response held until resp_ready. Option: LSU_MISALIGN_TRAP_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_ADDR_SIZE = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [1:0]            mem_maskmode,
  output logic                  mem_sext,
  output logic [DATA_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  localparam logic [DATA_WIDTH-1:0] ADDR_MASK =
    ((DATA_WIDTH'(1) << (MEM_ADDR_SIZE + 2)) - DATA_WIDTH'(1)) & ~DATA_WIDTH'(3);

  lsu_state_t            state;
  logic                  write_q;
  logic [2:0]            funct3_q;
  logic [1:0]            offset_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  mem_read_q;
  logic                  mem_write_q;

  lsu_size_t             req_size;
  logic                  trap;
  logic [DATA_WIDTH-1:0] eff_addr;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] extracted;

  assign req_size = f3_size(req_funct3);

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap     = (req_size == SZ_H && req_addr[0]) ||
                    (req_size == SZ_W && req_addr[1:0] != 2'b00);
  assign eff_addr = req_addr;
`else
  assign trap = 1'b0;
  // Misaligned halves/words silently drop the offending low address bits.
  always_comb begin
    eff_addr = req_addr;
    case (req_size)
      SZ_H:    eff_addr[0]   = 1'b0;
      SZ_W:    eff_addr[1:0] = 2'b00;
      default: eff_addr      = req_addr;
    endcase
  end
`endif

  assign req_ready    = (state == IDLE);
  assign resp_valid   = (state == RESP);
  assign mem_maskmode = MASK_WORD;
  assign mem_sext     = 1'b0;
  // Gating with reset kills a strobe in the very cycle reset is raised.
  assign mem_read     = mem_read_q & ~reset;
  assign mem_write    = mem_write_q & ~reset;

  lsu_byte_lane #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_byte_lane (
    .word      (mem_read_data),
    .wdata     (wdata_q),
    .offset    (offset_q),
    .funct3    (funct3_q),
    .merged    (merged),
    .extracted (extracted)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      write_q        <= 1'b0;
      funct3_q       <= '0;
      offset_q       <= '0;
      wdata_q        <= '0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      resp_rdata     <= '0;
      resp_error     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            write_q     <= req_write;
            funct3_q    <= req_funct3;
            offset_q    <= eff_addr[1:0];
            wdata_q     <= req_wdata;
            mem_address <= eff_addr & ADDR_MASK;
            resp_rdata  <= '0;
            resp_error  <= 1'b0;
            if (trap) begin
              resp_error <= 1'b1;
              state      <= RESP;
            end else if (req_write && req_size == SZ_W) begin
              mem_write_data <= req_wdata;
              mem_write_q    <= 1'b1;
              state          <= WRITE;
            end else begin
              mem_read_q <= 1'b1;
              state      <= READ;
            end
          end
        end
        READ: begin
          mem_read_q <= 1'b0;
          if (write_q) begin
            mem_write_data <= merged;
            mem_write_q    <= 1'b1;
            state          <= WRITE;
          end else begin
            resp_rdata <= extracted;
            state      <= RESP;
          end
        end
        WRITE: begin
          mem_write_q <= 1'b0;
          state       <= RESP;
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized traffic against a
// byte-level reference memory model; also honours LSU_MISALIGN_TRAP_EN.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_error;
  logic [31:0] resp_rdata;
  logic        mem_read, mem_write, mem_sext;
  logic [1:0]  mem_maskmode;
  logic [31:0] mem_address, mem_write_data, mem_read_data;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
  int n_checks = 0, n_pass = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .MEM_ADDR_SIZE(13)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_read(mem_read), .mem_write(mem_write), .mem_maskmode(mem_maskmode),
    .mem_sext(mem_sext), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  assign mem_read_data = mem[mem_address[9:2]];

  // Word memory: writes land on the falling edge; strobes counted there too.
  always @(negedge clk) begin
    if (mem_write) mem[mem_address[9:2]] = mem_write_data;
    if (mem_read) rd_cnt++;
    if (mem_write) wr_cnt++;
    if (mem_read && mem_write) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: byte-addressed semantics computed directly from the access rules.
  task automatic model(input bit w, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rdata, output bit err,
                       output int lat, output int nr, output int nw);
    int size, off, idx;
    bit sgn, mis;
    logic [31:0] a, word, v, m;
    size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    sgn  = (f3 == 3'd0 || f3 == 3'd1);
    mis  = (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00);
    rdata = 32'h0; err = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (mis) begin
      err = 1'b1; lat = 1; nr = 0; nw = 0;
      return;
    end
`else
    if (mis) err = 1'b0;
`endif
    a    = addr - (addr % size);
    off  = int'(a % 4);
    idx  = int'(a / 4);
    word = ref_mem[idx];
    if (!w) begin
      v = word >> (8 * off);
      if (size < 4) begin
        m = (32'd1 << (8 * size)) - 32'd1;
        v = v & m;
        if (sgn && v[8*size-1]) v = v | ~m;
      end
      rdata = v; lat = 2; nr = 1; nw = 0;
    end else begin
      for (int i = 0; i < size; i++) word[8*(off+i) +: 8] = wd[8*i +: 8];
      ref_mem[idx] = word;
      lat = (size == 4) ? 2 : 3; nr = (size == 4) ? 0 : 1; nw = 1;
    end
  endtask

  task automatic do_req(input bit w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input int hold, output logic [31:0] rd,
                        output logic er, output int lat, output int nr, output int nw);
    int r0, w0, guard;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    r0 = rd_cnt; w0 = wr_cnt;
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    rd = resp_rdata; er = resp_error;
    // Stall with a competing request that must be ignored.
    if (hold > 0) req_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", resp_valid, 1);
      chk("hold_rdata", resp_rdata, rd);
      chk("hold_req_ready", req_ready, 0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    nr = rd_cnt - r0; nw = wr_cnt - w0;
  endtask

  task automatic run_txn(input bit w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input int hold, output logic [31:0] rd);
    logic [31:0] e_rd;
    bit e_er;
    logic er;
    int e_lat, e_nr, e_nw, lat, nr, nw;
    model(w, f3, a, d, e_rd, e_er, e_lat, e_nr, e_nw);
    do_req(w, f3, a, d, hold, rd, er, lat, nr, nw);
    chk("rdata", rd, e_rd);
    chk("error", er, e_er);
    chk("latency", lat, e_lat);
    chk("mem_reads", nr, e_nr);
    chk("mem_writes", nw, e_nw);
  endtask

  initial begin
    logic [31:0] rd;
    logic [2:0]  f3;
    bit          w;
    int          r0, guard;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[16] = 32'h8899AABB; ref_mem[16] = 32'h8899AABB;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_error", resp_error, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_wdata", mem_write_data, 0);
    chk("rst_maskmode", mem_maskmode, 2'b10);
    chk("rst_sext", mem_sext, 0);

    run_txn(1'b0, 3'b000, 32'h43, 32'h0, 0, rd);
    chk("lb_0x43", rd, 32'hFFFFFF88);
    run_txn(1'b0, 3'b100, 32'h43, 32'h0, 5, rd);
    chk("lbu_0x43", rd, 32'h00000088);
    run_txn(1'b1, 3'b000, 32'h41, 32'h0000005A, 0, rd);
    chk("sb_merge", mem[16], 32'h88995ABB);
    run_txn(1'b1, 3'b010, 32'h80, 32'h12345678, 0, rd);
    chk("sw_word", mem[32], 32'h12345678);
    run_txn(1'b0, 3'b010, 32'h80, 32'h0, 0, rd);
    chk("lw_after_sw", rd, 32'h12345678);
    run_txn(1'b0, 3'b001, 32'h43, 32'h0, 0, rd);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lh_misaligned", rd, 32'h0);
`else
    chk("lh_misaligned", rd, 32'hFFFF8899);
`endif

    // Reset raised during the WRITE cycle of a byte store.
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    r0 = wr_cnt;
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h41; req_wdata = 32'h000000A5;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1;
    chk("wr_before_reset", mem_write, 1);
    reset = 1'b1;
    #1 chk("wr_suppressed", mem_write, 0);
    @(posedge clk); #1 reset = 1'b0;
    chk("rst_abort_ready", req_ready, 1);
    chk("rst_abort_valid", resp_valid, 0);
    chk("rst_abort_addr", mem_address, 0);
    chk("rst_abort_writes", wr_cnt - r0, 0);
    chk("rst_abort_mem", mem[16], 32'h88995ABB);

    for (int n = 0; n < 200; n++) begin
      w  = $urandom_range(0, 1);
      f3 = w ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      run_txn(w, f3, 32'($urandom_range(0, 1023)), $urandom, $urandom_range(0, 2), rd);
    end

    for (int i = 0; i < 256; i++) chk("mem_final", mem[i], ref_mem[i]);
    chk("rw_overlap", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
